// File: rtl/fifo_pkg.sv
// Shared types and constants for the sync_fifo read-side drain path.
// Occupancy encoding of the 2-slot output buffer plus the FIFO read latency it absorbs.
package fifo_pkg;

  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_RD_LAT = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Buffer slots committed after this edge: held words plus the returning read, minus the pop.
  function automatic logic [2:0] occ_level(input occ_t occ, input logic inflight, input logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the drainer.
// master = drainer side, slave = FIFO and consumer side.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_enable;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd_enable,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd_enable,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-slot HEAD/SKID output buffer; a pushed word is visible on head the cycle after the push edge.
// Holds head stable while stalled; caller must never push into a full buffer without popping.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output occ_t             occ
);

  logic [WIDTH-1:0] skid;
  logic             pop_ok;

  assign pop_ok = pop && valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ   <= OCC_EMPTY;
      head  <= '0;
      skid  <= '0;
      valid <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head  <= push_data;
            valid <= 1'b1;
            occ   <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && !pop_ok) begin
            skid <= push_data;
            occ  <= OCC_TWO;
          end else if (push && pop_ok) begin
            head <= push_data;
          end else if (pop_ok) begin
            valid <= 1'b0;
            occ   <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Push without pop cannot happen here; the issue logic reserves a slot per read.
          if (pop_ok) begin
            head <= skid;
            if (push) begin
              skid <= push_data;
            end else begin
              occ <= OCC_ONE;
            end
          end
        end
        default: begin
          occ   <= OCC_EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains sync_fifo onto a valid/ready stream; 2-edge latency from FIFO non-empty to m_valid, 1 word/cycle.
// Reads only when a buffer slot is reserved for the returning word, so m_ready low stalls reads after 2 words.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  fifo_rd_stream_if.master  bus,
  output logic [CNT_W-1:0]  xfer_count
);

  logic       inflight;
  logic       pop;
  logic       rd_accept;
  logic [2:0] level;
  occ_t       occ;

  assign pop   = bus.m_valid && bus.m_ready;
  assign level = occ_level(occ, inflight, pop);

  // Combinational from m_ready so a same-cycle pop frees a slot for the next read.
  assign bus.fifo_rd_enable = reset && en && !bus.fifo_empty && (level < 3'd2);
  assign rd_accept          = bus.fifo_rd_enable && !bus.fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight <= rd_accept;
      if (pop) begin
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head      (bus.m_data),
    .valid     (bus.m_valid),
    .occ       (occ)
  );

endmodule
